// File: rtl/regspace_ext_pkg.sv
// Shared types and width helpers for the register-space external bridge.
package regspace_ext_pkg;

  typedef enum logic [2:0] {
    RS_IDLE,
    RS_RD_EXT,
    RS_RD_RESP,
    RS_WR_EXT,
    RS_WR_RESP
  } rs_state_e;

  // Width of a register index; at least one bit so single-register builds stay legal.
  function automatic int unsigned idx_w(input int unsigned num_regs);
    return (num_regs > 1) ? $clog2(num_regs) : 1;
  endfunction

  // Number of byte-offset bits covered by one register stride.
  function automatic int unsigned off_w(input int unsigned stride);
    return $clog2(stride);
  endfunction

endpackage

// File: rtl/regspace_ext_bridge_if.sv
// Register-space request/response bus: read request, read ack, write request, write ack.
interface regspace_ext_bridge_if #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DATA_W = 32
);
  logic [ADDR_W-1:0] rreq_addr;
  logic              rreq_vld;
  logic              rreq_rdy;
  logic [DATA_W-1:0] rack_data;
  logic              rack_err;
  logic              rack_vld;
  logic              rack_rdy;
  logic [ADDR_W-1:0] wreq_addr;
  logic [DATA_W-1:0] wreq_data;
  logic              wreq_vld;
  logic              wreq_rdy;
  logic              wack_vld;
  logic              wack_err;

  modport master (
    output rreq_addr, rreq_vld, rack_rdy, wreq_addr, wreq_data, wreq_vld,
    input  rreq_rdy, rack_data, rack_err, rack_vld, wreq_rdy, wack_vld, wack_err
  );

  modport slave (
    input  rreq_addr, rreq_vld, rack_rdy, wreq_addr, wreq_data, wreq_vld,
    output rreq_rdy, rack_data, rack_err, rack_vld, wreq_rdy, wack_vld, wack_err
  );
endinterface

// File: rtl/regspace_ext_decode.sv
// Combinational address decode: addr -> {hit, register index}.
module regspace_ext_decode
  import regspace_ext_pkg::*;
#(
  parameter int unsigned ADDR_W     = 16,
  parameter int unsigned NUM_REGS   = 4,
  parameter int unsigned BASE_ADDR  = 0,
  parameter int unsigned REG_STRIDE = 32,
  localparam int unsigned IDX_W     = idx_w(NUM_REGS),
  localparam int unsigned OFF_W     = off_w(REG_STRIDE)
) (
  input  logic [ADDR_W-1:0] addr_i,
  output logic              hit_o,
  output logic [IDX_W-1:0]  idx_o
);

  logic [ADDR_W-1:0] off;
  logic [ADDR_W-1:0] idx_full;

  // A mask instead of off[OFF_W-1:0] keeps a stride of 1 (OFF_W==0) legal.
  always_comb begin
    off      = addr_i - ADDR_W'(BASE_ADDR);
    idx_full = off >> OFF_W;
    hit_o    = ((off & ADDR_W'(REG_STRIDE - 1)) == '0) && (idx_full < ADDR_W'(NUM_REGS));
    idx_o    = idx_full[IDX_W-1:0];
  end

endmodule

// File: rtl/regspace_ext_bridge.sv
// Bridge from the register-space request bus to NUM_REGS external registers.
// Single outstanding transaction; write wins over read in the same cycle.
// Optional: define REGSPACE_EXT_TIMEOUT_EN to abort ext handshakes after TIMEOUT_CYC cycles.
module regspace_ext_bridge
  import regspace_ext_pkg::*;
#(
  parameter int unsigned ADDR_W      = 16,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned NUM_REGS    = 4,
  parameter int unsigned BASE_ADDR   = 0,
  parameter int unsigned REG_STRIDE  = 32,
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic                       clk,
  input  logic                       rst,
  regspace_ext_bridge_if.slave       bus,
  output logic [NUM_REGS-1:0]        ext_rvld,
  input  logic [NUM_REGS-1:0]        ext_rrdy,
  input  logic [NUM_REGS*DATA_W-1:0] ext_rdat,
  output logic [NUM_REGS-1:0]        ext_wvld,
  input  logic [NUM_REGS-1:0]        ext_wrdy,
  output logic [DATA_W-1:0]          ext_wdat
);

  localparam int unsigned IDX_W = idx_w(NUM_REGS);

  if (NUM_REGS < 1 || NUM_REGS > 64) begin : g_chk_regs
    $error("NUM_REGS out of range");
  end
  if ((REG_STRIDE == 0) || ((REG_STRIDE & (REG_STRIDE - 1)) != 0)) begin : g_chk_stride
    $error("REG_STRIDE must be a power of two");
  end
  if (TIMEOUT_CYC == 0) begin : g_chk_to
    $error("TIMEOUT_CYC must be non-zero");
  end

  rs_state_e         state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [DATA_W-1:0] wdat_q, wdat_d;
  logic [DATA_W-1:0] rdat_q, rdat_d;
  logic              rerr_q, rerr_d;
  logic              werr_q, werr_d;
  logic              rhit, whit;
  logic [IDX_W-1:0]  ridx, widx;

`ifdef REGSPACE_EXT_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             timeout;
  assign timeout = (int'(cnt_q) + 1) >= int'(TIMEOUT_CYC);
`endif

  regspace_ext_decode #(
    .ADDR_W(ADDR_W), .NUM_REGS(NUM_REGS), .BASE_ADDR(BASE_ADDR), .REG_STRIDE(REG_STRIDE)
  ) u_rdec (
    .addr_i(bus.rreq_addr), .hit_o(rhit), .idx_o(ridx)
  );

  regspace_ext_decode #(
    .ADDR_W(ADDR_W), .NUM_REGS(NUM_REGS), .BASE_ADDR(BASE_ADDR), .REG_STRIDE(REG_STRIDE)
  ) u_wdec (
    .addr_i(bus.wreq_addr), .hit_o(whit), .idx_o(widx)
  );

  // State and latched transaction registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RS_IDLE;
      idx_q   <= '0;
      wdat_q  <= '0;
      rdat_q  <= '0;
      rerr_q  <= 1'b0;
      werr_q  <= 1'b0;
`ifdef REGSPACE_EXT_TIMEOUT_EN
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      wdat_q  <= wdat_d;
      rdat_q  <= rdat_d;
      rerr_q  <= rerr_d;
      werr_q  <= werr_d;
`ifdef REGSPACE_EXT_TIMEOUT_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  // Next-state: accept, external handshake, response.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    wdat_d  = wdat_q;
    rdat_d  = rdat_q;
    rerr_d  = rerr_q;
    werr_d  = werr_q;
`ifdef REGSPACE_EXT_TIMEOUT_EN
    cnt_d   = cnt_q;
`endif
    unique case (state_q)
      RS_IDLE: begin
`ifdef REGSPACE_EXT_TIMEOUT_EN
        cnt_d = '0;
`endif
        if (bus.wreq_vld) begin
          idx_d   = widx;
          wdat_d  = bus.wreq_data;
          werr_d  = !whit;
          state_d = whit ? RS_WR_EXT : RS_WR_RESP;
        end else if (bus.rreq_vld) begin
          idx_d   = ridx;
          rdat_d  = '0;
          rerr_d  = !rhit;
          state_d = rhit ? RS_RD_EXT : RS_RD_RESP;
        end
      end
      RS_RD_EXT: begin
        if (ext_rrdy[idx_q]) begin
          rdat_d  = ext_rdat[int'(idx_q)*DATA_W +: DATA_W];
          rerr_d  = 1'b0;
          state_d = RS_RD_RESP;
        end
`ifdef REGSPACE_EXT_TIMEOUT_EN
        else if (timeout) begin
          rdat_d  = '0;
          rerr_d  = 1'b1;
          state_d = RS_RD_RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      RS_RD_RESP: begin
        if (bus.rack_rdy) state_d = RS_IDLE;
      end
      RS_WR_EXT: begin
        if (ext_wrdy[idx_q]) begin
          werr_d  = 1'b0;
          state_d = RS_WR_RESP;
        end
`ifdef REGSPACE_EXT_TIMEOUT_EN
        else if (timeout) begin
          werr_d  = 1'b1;
          state_d = RS_WR_RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      RS_WR_RESP: state_d = RS_IDLE;
      default:    state_d = RS_IDLE;
    endcase
  end

  // Strobes are decoded from registered state/index, so they are glitch-free and one-hot.
  always_comb begin
    ext_rvld = '0;
    ext_wvld = '0;
    if (state_q == RS_RD_EXT) ext_rvld[idx_q] = 1'b1;
    if (state_q == RS_WR_EXT) ext_wvld[idx_q] = 1'b1;
  end

  assign ext_wdat      = wdat_q;
  assign bus.rreq_rdy  = (state_q == RS_IDLE) && !bus.wreq_vld;
  assign bus.wreq_rdy  = (state_q == RS_IDLE);
  assign bus.rack_vld  = (state_q == RS_RD_RESP);
  assign bus.rack_data = rdat_q;
  assign bus.rack_err  = rerr_q;
  assign bus.wack_vld  = (state_q == RS_WR_RESP);
  assign bus.wack_err  = werr_q;

endmodule
